mul_iter_param: RTL
===================

MUL_ITER_PARAM -- requirements
Module: mul_iter_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL provide parameter BITS_PER_CYCLE, default 2, multiplier bits retired per MULTIPLY cycle; legal values 1, 2, 4; must divide WIDTH.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  1  request; four-phase handshake with ack.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 hi_sel  input  1  1 = return product[2*WIDTH-1:WIDTH], 0 = product[WIDTH-1:0].
REQ-011 out  output  WIDTH  selected product half, registered.
REQ-012 ack  output  1  result valid; held until req falls.
REQ-013 busy  output  1  high in MULTIPLY and FINISH.

Function
REQ-014 SHALL implement states IDLE, MULTIPLY, FINISH, WAIT_FOR_REQ_LOW; any other encoding SHALL return to IDLE.
REQ-015 IDLE: on req=1 SHALL latch a, b, is_signed, hi_sel; clear 2*WIDTH-bit product and bit counter; go to MULTIPLY.
REQ-016 Signed capture SHALL store |a|, |b| as WIDTH-bit unsigned magnitudes (0x80..0 -> 2^(WIDTH-1)) and record neg = a[MSB]^b[MSB]; unsigned capture SHALL set neg=0.
REQ-017 MULTIPLY: each cycle SHALL add (multiplicand * low BITS_PER_CYCLE multiplier bits) << bit_count into product, shift multiplier right by BITS_PER_CYCLE, advance bit_count by BITS_PER_CYCLE.
REQ-018 MULTIPLY SHALL go to FINISH on the cycle retiring the last WIDTH/BITS_PER_CYCLE group.
REQ-019 FINISH: SHALL apply two's-complement negation to the full 2*WIDTH product if neg=1, load out with the half chosen by latched hi_sel, set ack=1, go to WAIT_FOR_REQ_LOW.
REQ-020 WAIT_FOR_REQ_LOW: while req=1 SHALL hold ack=1 and out stable; on req=0 SHALL clear ack and go to IDLE.
REQ-021 Fixed latency: counting the accepting edge as edge 1, ack SHALL rise on edge WIDTH/BITS_PER_CYCLE + 2 (18 for default parameters).
REQ-022 a, b, is_signed, hi_sel changes outside IDLE SHALL have no effect.
REQ-023 A new operation SHALL NOT start until req has been observed low after ack; back-to-back start is possible on the edge after returning to IDLE.
REQ-024 out SHALL retain the last result until the next FINISH.
REQ-025 Product arithmetic SHALL be exact modulo 2^(2*WIDTH), with no overflow flag.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, out=0, ack=0, busy=0, and clear all internal registers.
REQ-027 Reset during any state SHALL abort the operation with no partial result.
REQ-028 If req=1 at reset release, the first clk edge SHALL accept a new operation.

Configuration
REQ-029 Macro MUL_EARLY_TERM_EN defined: MULTIPLY SHALL go to FINISH after any iteration leaving the remaining shifted multiplier zero.
REQ-030 With MUL_EARLY_TERM_EN, at least one iteration SHALL always run, and results SHALL be identical to the fixed-latency build.
REQ-031 Macro MUL_EARLY_TERM_EN undefined: latency SHALL be fixed per REQ-021.

Verification (WIDTH=32, BITS_PER_CYCLE=2)
REQ-032 Unsigned 0x00010000*0x00010000: hi_sel=1 -> out=0x00000001; hi_sel=0 -> out=0x00000000; ack on edge 18.
REQ-033 Signed 0xFFFFFFFD*0x00000007: hi_sel=0 -> out=0xFFFFFFEB; hi_sel=1 -> out=0xFFFFFFFF.
REQ-034 Signed 0x80000000*0x80000000: hi_sel=1 -> out=0x40000000; hi_sel=0 -> out=0x00000000.
REQ-035 Handshake: hold req high 5 cycles past ack and change a mid-MULTIPLY -> ack stays 1, out unchanged, single operation only.
REQ-036 Reset: assert rst at edge 8 of MULTIPLY -> ack=0, out=0, busy=0 without a clock edge; a new request then completes correctly.
REQ-037 Unsigned 5*3: with MUL_EARLY_TERM_EN -> out=15, ack on edge 3; without it -> out=15, ack on edge 18.

Source files
------------

// File: rtl/mul_iter_param_if.sv
// Request/result bundle for mul_iter_param: four-phase req/ack handshake,
// operands and controls from the master, result and status from the slave.
interface mul_iter_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             hi_sel;
  logic [WIDTH-1:0] out;
  logic             ack;
  logic             busy;

  modport master (
    output req, a, b, is_signed, hi_sel,
    input  out, ack, busy
  );

  modport slave (
    input  req, a, b, is_signed, hi_sel,
    output out, ack, busy
  );
endinterface

// File: rtl/mul_iter_param.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Optional MUL_EARLY_TERM_EN ends MULTIPLY once the remaining multiplier is zero.
module mul_iter_param #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  mul_iter_param_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned GW = WIDTH + BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULTIPLY,
    S_FINISH,
    S_WAIT_REQ_LOW
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             neg_q, neg_d;
  logic             hi_sel_q, hi_sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_mag_c, b_mag_c, mplier_shr_c;
  logic [GW-1:0]    partial_c;
  logic [PW-1:0]    product_sum_c, result_c;
  logic             last_c, done_c;

  // Sign-magnitude capture: the most negative value maps to 2^(WIDTH-1).
  assign a_mag_c = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag_c = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign partial_c     = GW'(mcand_q) * GW'(mplier_q[BITS_PER_CYCLE-1:0]);
  assign product_sum_c = product_q + (PW'(partial_c) << bit_cnt_q);
  assign mplier_shr_c  = mplier_q >> BITS_PER_CYCLE;
  assign result_c      = neg_q ? -product_q : product_q;
  assign last_c        = (bit_cnt_q == CW'(WIDTH - BITS_PER_CYCLE));

`ifdef MUL_EARLY_TERM_EN
  assign done_c = last_c || (mplier_shr_c == '0);
`else
  assign done_c = last_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      bit_cnt_q <= '0;
      neg_q     <= 1'b0;
      hi_sel_q  <= 1'b0;
      out_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      bit_cnt_q <= bit_cnt_d;
      neg_q     <= neg_d;
      hi_sel_q  <= hi_sel_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    bit_cnt_d = bit_cnt_q;
    neg_d     = neg_q;
    hi_sel_d  = hi_sel_q;
    out_d     = out_q;
    ack_d     = ack_q;

    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        if (bus.req) begin
          mcand_d   = a_mag_c;
          mplier_d  = b_mag_c;
          neg_d     = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          hi_sel_d  = bus.hi_sel;
          product_d = '0;
          bit_cnt_d = '0;
          state_d   = S_MULTIPLY;
        end
      end
      S_MULTIPLY: begin
        product_d = product_sum_c;
        mplier_d  = mplier_shr_c;
        bit_cnt_d = bit_cnt_q + CW'(BITS_PER_CYCLE);
        if (done_c) state_d = S_FINISH;
      end
      S_FINISH: begin
        out_d   = hi_sel_q ? result_c[PW-1:WIDTH] : result_c[WIDTH-1:0];
        ack_d   = 1'b1;
        state_d = S_WAIT_REQ_LOW;
      end
      S_WAIT_REQ_LOW: begin
        if (!bus.req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MULTIPLY) || (state_d == S_FINISH);
  end

  assign bus.out  = out_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;

endmodule
